// File: rtl/pixel_row_readout.sv
// Captures a parallel pixel row during READ and streams it one pixel per cycle
// over valid/ready, tagged with row index and first/last markers; rows arriving mid-stream are dropped.
module pixel_row_readout #(
    parameter int PIXEL_ARRAY_WIDTH = 4,
    parameter int CAPTURE_DELAY     = 1,
    parameter int N_ROWS            = 4,
    parameter int ROW_BITS          = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           READ,
    input  logic [PIXEL_ARRAY_WIDTH*8-1:0] ROW_DATA,
    input  logic                           OUT_READY,
    input  logic                           OVERRUN_CLR,
    output logic                           OUT_VALID,
    output logic [7:0]                     OUT_DATA,
    output logic                           OUT_FIRST,
    output logic                           OUT_LAST,
    output logic [ROW_BITS-1:0]            OUT_ROW,
    output logic                           BUSY,
    output logic                           OVERRUN
);

    localparam int IDX_W = $clog2(PIXEL_ARRAY_WIDTH);
    localparam int CNT_W = $clog2(CAPTURE_DELAY + 2);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(PIXEL_ARRAY_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(N_ROWS - 1);
    localparam logic [CNT_W-1:0]    CNT_HIT  = CNT_W'(CAPTURE_DELAY);
    localparam logic [CNT_W-1:0]    CNT_SAT  = CNT_W'(CAPTURE_DELAY + 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [CNT_W-1:0]               r_run_cnt;
    logic [PIXEL_ARRAY_WIDTH*8-1:0] r_buf;
    logic [IDX_W-1:0]               r_idx;
    logic [ROW_BITS-1:0]            r_row_cnt;
    logic [ROW_BITS-1:0]            r_out_row;
    logic                           r_overrun;
    logic [7:0]                     w_pix [PIXEL_ARRAY_WIDTH];

    logic w_capture;
    logic w_streaming;
    logic w_xfer;
    logic w_last;
    logic w_row_done;
    logic w_accept;
    logic w_drop;

    generate
        for (genvar gi = 0; gi < PIXEL_ARRAY_WIDTH; gi++) begin : g_pix
            assign w_pix[gi] = r_buf[gi*8 +: 8];
        end
    endgenerate

    assign w_capture   = READ && (r_run_cnt == CNT_HIT);
    assign w_streaming = (r_state == S_STREAM);
    assign w_xfer      = w_streaming && OUT_READY;
    assign w_last      = (r_idx == LAST_IDX);
    assign w_row_done  = w_xfer && w_last;
    // A capture landing on the final transfer chains straight into the next row.
    assign w_accept    = w_capture && (!w_streaming || w_row_done);
    assign w_drop      = w_capture && !w_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_capture) w_state_next = S_STREAM;
            S_STREAM: if (w_row_done && !w_capture) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        OUT_VALID = 1'b0;
        OUT_DATA  = 8'd0;
        OUT_FIRST = 1'b0;
        OUT_LAST  = 1'b0;
        OUT_ROW   = '0;
        BUSY      = 1'b0;
        OVERRUN   = r_overrun;
        if (w_streaming) begin
            OUT_VALID = 1'b1;
            OUT_DATA  = w_pix[r_idx];
            OUT_FIRST = (r_idx == '0);
            OUT_LAST  = w_last;
            OUT_ROW   = r_out_row;
            BUSY      = 1'b1;
        end
    end

    // Row counter advances on every capture, dropped or not, so frame indices stay true.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_cnt <= '0;
            r_buf     <= '0;
            r_idx     <= '0;
            r_row_cnt <= '0;
            r_out_row <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (!READ) begin
                r_run_cnt <= '0;
            end else if (r_run_cnt != CNT_SAT) begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end

            if (w_accept) begin
                r_buf     <= ROW_DATA;
                r_idx     <= '0;
                r_out_row <= r_row_cnt;
            end else if (w_xfer && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_capture) begin
                r_row_cnt <= (r_row_cnt == ROW_LAST) ? '0 : r_row_cnt + 1'b1;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (OVERRUN_CLR) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_row_readout.sv
// Scoreboard bench for pixel_row_readout: stimulus pushes expected pixels,
// a negedge monitor compares each presented pixel against the queue head.
module tb_pixel_row_readout;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          READ = 1'b0;
    logic [W*8-1:0] ROW_DATA = '0;
    logic          OUT_READY = 1'b0;
    logic          OVERRUN_CLR = 1'b0;
    logic          OUT_VALID;
    logic [7:0]    OUT_DATA;
    logic          OUT_FIRST;
    logic          OUT_LAST;
    logic [7:0]    OUT_ROW;
    logic          BUSY;
    logic          OVERRUN;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        logic       l;
        logic [7:0] row;
    } exp_t;

    exp_t q[$];

    bit   bp_en = 1'b0;
    logic bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   bp_i = 0;

    logic [31:0] rows5 [5] = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 32'hD3D2D1D0, 32'hE3E2E1E0};

    pixel_row_readout #(
        .PIXEL_ARRAY_WIDTH(W),
        .CAPTURE_DELAY(1),
        .N_ROWS(4),
        .ROW_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .READ(READ),
        .ROW_DATA(ROW_DATA),
        .OUT_READY(OUT_READY),
        .OVERRUN_CLR(OVERRUN_CLR),
        .OUT_VALID(OUT_VALID),
        .OUT_DATA(OUT_DATA),
        .OUT_FIRST(OUT_FIRST),
        .OUT_LAST(OUT_LAST),
        .OUT_ROW(OUT_ROW),
        .BUSY(BUSY),
        .OVERRUN(OVERRUN)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_en) begin
            OUT_READY = bp_pat[bp_i];
            bp_i = (bp_i + 1) % 4;
        end
    endtask

    task automatic push_row(input logic [31:0] data, input logic [7:0] row);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.d   = data[8*i +: 8];
            e.f   = (i == 0);
            e.l   = (i == W - 1);
            e.row = row;
            q.push_back(e);
        end
    endtask

    task automatic read_pulse(input int len, input logic [31:0] data);
        ROW_DATA = data;
        READ = 1'b1;
        repeat (len) tick();
        READ = 1'b0;
        ROW_DATA = 32'hDEADBEEF;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((BUSY || q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_drain: busy=%0d pending=%0d want busy=0 pending=0", name, BUSY, q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Compare every presented pixel with the queue head; pop only on an actual transfer.
    always @(negedge clk) begin
        if (!reset && OUT_VALID) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got data=%02h row=%0d want none", OUT_DATA, OUT_ROW);
            end else begin
                check("pixel{row,data,first,last}",
                      {14'd0, OUT_ROW, OUT_DATA, OUT_FIRST, OUT_LAST},
                      {14'd0, q[0].row, q[0].d, q[0].f, q[0].l});
                if (OUT_READY) begin
                    $display("xfer row=%0d data=%02h first=%0d last=%0d", OUT_ROW, OUT_DATA, OUT_FIRST, OUT_LAST);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_data", {24'd0, OUT_DATA}, 32'd0);
        check("rst_first_last", {30'd0, OUT_FIRST, OUT_LAST}, 32'd0);
        check("rst_row", {24'd0, OUT_ROW}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_overrun", {31'd0, OVERRUN}, 32'd0);
        reset = 1'b0;
        OUT_READY = 1'b1;

        // Single row: capture on READ's 2nd cycle, valid one cycle later
        push_row(32'h44332211, 8'd0);
        ROW_DATA = 32'h44332211;
        READ = 1'b1;
        tick();
        check("lat_before_capture", {31'd0, OUT_VALID}, 32'd0);
        tick();
        check("lat_after_capture", {31'd0, OUT_VALID}, 32'd1);
        check("busy_streaming", {31'd0, BUSY}, 32'd1);
        repeat (3) tick();
        READ = 1'b0;
        wait_idle("single");
        check("single_idle_busy", {31'd0, BUSY}, 32'd0);
        check("single_idle_valid", {31'd0, OUT_VALID}, 32'd0);

        // Backpressure with OUT_READY pattern 1,0,0,1
        push_row(32'h44332211, 8'd1);
        bp_en = 1'b1;
        read_pulse(5, 32'h44332211);
        wait_idle("backpressure");
        bp_en = 1'b0;
        OUT_READY = 1'b1;

        // Row wrap: 0,1,2,3,0
        do_reset();
        for (int r = 0; r < 5; r++) begin
            push_row(rows5[r], 8'(r % 4));
            read_pulse(3, rows5[r]);
            wait_idle("wrap");
        end
        check("wrap_overrun", {31'd0, OVERRUN}, 32'd0);

        // Overrun: row A held by backpressure, row B dropped, row C tagged 2
        do_reset();
        OUT_READY = 1'b0;
        push_row(32'h0A0B0C0D, 8'd0);
        read_pulse(3, 32'h0A0B0C0D);
        repeat (2) tick();
        read_pulse(3, 32'h99887766);
        check("overrun_set", {31'd0, OVERRUN}, 32'd1);
        OUT_READY = 1'b1;
        wait_idle("overrun_a");
        push_row(32'h5A6B7C8D, 8'd2);
        read_pulse(3, 32'h5A6B7C8D);
        wait_idle("overrun_c");
        check("overrun_sticky", {31'd0, OVERRUN}, 32'd1);
        OVERRUN_CLR = 1'b1;
        tick();
        OVERRUN_CLR = 1'b0;
        check("overrun_clr", {31'd0, OVERRUN}, 32'd0);

        // Back-to-back: capture of Y coincides with last transfer of X
        push_row(32'h13121110, 8'd3);
        push_row(32'h23222120, 8'd0);
        read_pulse(2, 32'h13121110);
        check("b2b_valid0", {31'd0, OUT_VALID}, 32'd1);
        tick();
        check("b2b_valid1", {31'd0, OUT_VALID}, 32'd1);
        tick();
        check("b2b_valid2", {31'd0, OUT_VALID}, 32'd1);
        ROW_DATA = 32'h23222120;
        READ = 1'b1;
        tick();
        check("b2b_valid3", {31'd0, OUT_VALID}, 32'd1);
        check("b2b_x_last", {31'd0, OUT_LAST}, 32'd1);
        tick();
        check("b2b_valid4", {31'd0, OUT_VALID}, 32'd1);
        check("b2b_y_first", {31'd0, OUT_FIRST}, 32'd1);
        check("b2b_y_data", {24'd0, OUT_DATA}, 32'h20);
        READ = 1'b0;
        wait_idle("b2b");
        check("b2b_overrun", {31'd0, OVERRUN}, 32'd0);

        // Short READ pulse produces no capture
        read_pulse(1, 32'h12345678);
        repeat (3) tick();
        check("short_valid", {31'd0, OUT_VALID}, 32'd0);
        check("short_busy", {31'd0, BUSY}, 32'd0);

        // Reset after two pixels have streamed
        push_row(32'h37363534, 8'd1);
        read_pulse(2, 32'h37363534);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_valid", {31'd0, OUT_VALID}, 32'd0);
        check("midrst_row", {24'd0, OUT_ROW}, 32'd0);
        check("midrst_busy", {31'd0, BUSY}, 32'd0);
        reset = 1'b0;
        q.delete();
        push_row(32'h47464544, 8'd0);
        read_pulse(3, 32'h47464544);
        wait_idle("post_reset");

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_row_readout.md
Name: pixel_row_readout

Overview:
- Downstream stage of the pixel row.
- Captures the row's parallel 8-bit-per-pixel DATA_OUT bus during the READ phase and serialises it into a one-pixel-per-cycle valid/ready stream, tagged with row index and first/last markers.
- Detects rows that arrive while the previous row is still streaming and flags them as overruns.
- Sits between the pixel row array and the image output interface.

Parameters:
- PIXEL_ARRAY_WIDTH, 4: pixels per row; must be ≥ 2.
- CAPTURE_DELAY, 1: number of READ-high cycles to skip before sampling ROW_DATA, so the row's output bus can settle.
- N_ROWS, 4: rows per frame; the row index wraps after N_ROWS-1.
- ROW_BITS, 8: width of the row index output; must satisfy N_ROWS ≤ 2^ROW_BITS.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- READ  in  1  read strobe from the sensor controller; held high for several cycles per row.
- ROW_DATA  in  PIXEL_ARRAY_WIDTH*8  packed row bus; pixel i is bits [8i+7:8i].
- OUT_READY  in  1  downstream accepts the current pixel.
- OVERRUN_CLR  in  1  clears the sticky OVERRUN flag.
- OUT_VALID  out  1  OUT_DATA holds a valid pixel.
- OUT_DATA  out  8  pixel value.
- OUT_FIRST  out  1  current pixel is pixel 0 of the row.
- OUT_LAST  out  1  current pixel is pixel PIXEL_ARRAY_WIDTH-1.
- OUT_ROW  out  ROW_BITS  row index of the row being streamed.
- BUSY  out  1  a row is held or streaming.
- OVERRUN  out  1  sticky: a row was dropped.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, pixel index = 0, row counter = 0, read-run counter = 0, capture buffer = 0. A reset mid-stream abandons the row; no partial output follows it.
- Read-run counter:
  - Counts consecutive cycles with READ=1; cleared on any cycle with READ=0.
  - Saturates once it passes CAPTURE_DELAY.
  - A capture event fires on the cycle where READ=1 and the counter equals CAPTURE_DELAY. This gives exactly one event per READ pulse.
  - A READ pulse shorter than CAPTURE_DELAY+1 cycles produces no event.
- FSM state IDLE:
  - On a capture event, ROW_DATA is latched into the buffer, pixel index is set to 0, and the FSM moves to STREAM.
  - OUT_VALID rises on the cycle after the capture edge (latency 1).
- FSM state STREAM:
  - OUT_VALID=1; OUT_DATA = buffer pixel[index].
  - OUT_FIRST = (index==0); OUT_LAST = (index==PIXEL_ARRAY_WIDTH-1).
  - OUT_ROW = row counter; BUSY=1.
  - Handshake: a transfer occurs on a posedge with OUT_VALID&OUT_READY. With OUT_READY=0, OUT_DATA, OUT_FIRST, OUT_LAST and OUT_ROW hold stable.
  - On a transfer with index < W-1: index increments.
  - On a transfer with index = W-1: row completes, and the row counter increments, wrapping from N_ROWS-1 to 0.
    - If a capture event occurs on the same cycle: the new row is latched, index returns to 0, the FSM stays in STREAM, and OUT_ROW shows the incremented value. This is back-to-back streaming with no bubble and is not an overrun.
    - Otherwise the FSM moves to IDLE and OUT_VALID=0 on the next cycle.
  - A capture event in STREAM other than on the final transfer: the row is dropped, the buffer is untouched, and OVERRUN is set on the next cycle. The row counter also increments so that later rows keep their true frame index.
- OVERRUN:
  - Set by a dropped row; cleared by OVERRUN_CLR.
  - If a set and OVERRUN_CLR occur on the same cycle, set wins.
- The buffer is only written on an accepted capture. ROW_DATA changes outside that cycle have no effect.

Test Plan:
- Single row: W=4, ROW_DATA=0x44332211, READ high 5 cycles, OUT_READY=1 → capture on READ's 2nd cycle. Pixels 0x11, 0x22, 0x33, 0x44 appear on 4 consecutive cycles starting 1 cycle after capture. OUT_FIRST is high on 0x11 only, OUT_LAST on 0x44 only, OUT_ROW=0. FSM then returns to IDLE with BUSY=0.
- Backpressure: same row, OUT_READY toggling 1,0,0,1,… → each pixel holds stable while OUT_READY=0. All 4 pixels are delivered in order with no duplicates or losses.
- Row wrap: 5 rows with N_ROWS=4 and spaced READ pulses → OUT_ROW sequence is 0,1,2,3,0; OVERRUN stays 0.
- Overrun: OUT_READY=0 after capture of row A, then a second READ pulse with ROW_DATA=B → OVERRUN=1, and row A is still output intact once OUT_READY=1. Next row shows OUT_ROW=2. OVERRUN_CLR pulse returns OVERRUN to 0.
- Back-to-back: capture event timed on the same cycle as the final transfer of the previous row → OUT_VALID stays continuously high, the new row's pixel 0 follows with OUT_FIRST=1, and OVERRUN=0.
- Short READ / reset mid-stream: a 1-cycle READ pulse gives no capture, OUT_VALID=0. Reset asserted after 2 pixels have streamed → OUT_VALID=0 and OUT_ROW=0 on the cycle after the reset edge; the next READ pulse streams from pixel 0.
